// File: rtl/wb_shim_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_shim_pkg                                                     |
// | Purpose  : Shared types and bounds for the Wishbone shim bridge.           |
// |            - wb_state_e      : per-channel FSM state encoding              |
// |            - wb_rsp_flags_t  : response-stage control half {ack, err}      |
// |            - RSP_STAGES_MIN/MAX : legal response pipeline depth            |
// |            The data half of a response stage is XLEN wide, so the full     |
// |            stage struct {dat, flg} is declared inside wb_shim_port.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package wb_shim_pkg;

  localparam int RSP_STAGES_MIN = 1;
  localparam int RSP_STAGES_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DRAIN = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic ack;
    logic err;
  } wb_rsp_flags_t;

endpackage : wb_shim_pkg
`default_nettype wire

// File: rtl/wb_shim_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_shim_port                                                    |
// | Purpose  : One Wishbone classic bridge channel: registers the core         |
// |            request, runs one outstanding slave transaction and returns     |
// |            the response through RSP_STAGES register stages.                |
// | Ports    : clk, rst_n (async, active low)                                  |
// |            i_c_adr/sel/we/stb/cyc/dat_w : core request                     |
// |            o_c_dat_r/ack/err            : response to core                 |
// |            o_b_adr/sel/we/stb/cyc/dat_w : registered request to slave      |
// |            i_b_dat_r/ack                : slave response                   |
// | Macro    : WB_SHIM_TIMEOUT_EN enables the BUS-phase timeout (c_err).       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wb_shim_port
  import wb_shim_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RSP_STAGES = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   i_c_adr,
  input  logic [XLEN/8-1:0] i_c_sel,
  input  logic              i_c_we,
  input  logic              i_c_stb,
  input  logic              i_c_cyc,
  input  logic [XLEN-1:0]   i_c_dat_w,
  output logic [XLEN-1:0]   o_c_dat_r,
  output logic              o_c_ack,
  output logic              o_c_err,
  output logic [XLEN-1:0]   o_b_adr,
  output logic [XLEN/8-1:0] o_b_sel,
  output logic              o_b_we,
  output logic              o_b_stb,
  output logic              o_b_cyc,
  output logic [XLEN-1:0]   o_b_dat_w,
  input  logic [XLEN-1:0]   i_b_dat_r,
  input  logic              i_b_ack
);

  typedef struct packed {
    logic [XLEN-1:0] dat;
    wb_rsp_flags_t   flg;
  } rsp_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("wb_shim_port: TIMEOUT must be >= 1");
  end

  wb_state_e         r_state;
  wb_state_e         w_state_nxt;
  logic [XLEN-1:0]   r_adr;
  logic [XLEN/8-1:0] r_sel;
  logic              r_we;
  logic [XLEN-1:0]   r_dat_w;
  rsp_t              r_stg [RSP_STAGES];
  rsp_t              w_rsp_in;
  rsp_t              w_last;
  logic              w_accept;
  logic              w_bus_ack;
  logic              w_bus_err;
  logic              w_expire;

  assign w_last = r_stg[RSP_STAGES-1];

`ifdef WB_SHIM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;

  // r_cnt holds the number of BUS cycles already completed, so expiry fires
  // in the TIMEOUT-th BUS cycle and the slave is driven for exactly TIMEOUT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (w_accept)           r_cnt <= '0;
    else if (r_state == ST_BUS)  r_cnt <= r_cnt + 1'b1;
  end

  assign w_expire = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign o_c_err  = w_last.flg.err;
`else
  assign w_expire = 1'b0;
  assign o_c_err  = 1'b0;
`endif

  // Priority in BUS: core abort, then slave ack, then timeout expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_bus_ack   = 1'b0;
    w_bus_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_c_cyc && i_c_stb) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUS;
        end
      end
      ST_BUS: begin
        if (!i_c_cyc) begin
          w_state_nxt = ST_IDLE;
        end else if (i_b_ack) begin
          w_bus_ack   = 1'b1;
          w_state_nxt = ST_DRAIN;
        end else if (w_expire) begin
          w_bus_err   = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as the response reaches the core so a still-high strobe is
        // accepted in the following cycle.
        if (w_last.flg.ack || w_last.flg.err) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rsp_in.flg.ack = w_bus_ack;
    w_rsp_in.flg.err = w_bus_err;
    w_rsp_in.dat     = w_bus_ack ? i_b_dat_r : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_dat_w <= '0;
    end else if (w_accept) begin
      r_adr   <= i_c_adr;
      r_sel   <= i_c_sel;
      r_we    <= i_c_we;
      r_dat_w <= i_c_dat_w;
    end
  end

  // Flags shift every cycle; data only moves alongside a valid flag so the
  // last stage keeps the previous response data until the next one arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_STAGES; i++) r_stg[i] <= '0;
    end else begin
      r_stg[0].flg <= w_rsp_in.flg;
      if (w_rsp_in.flg.ack || w_rsp_in.flg.err) r_stg[0].dat <= w_rsp_in.dat;
      for (int i = 1; i < RSP_STAGES; i++) begin
        r_stg[i].flg <= r_stg[i-1].flg;
        if (r_stg[i-1].flg.ack || r_stg[i-1].flg.err) r_stg[i].dat <= r_stg[i-1].dat;
      end
    end
  end

  assign o_c_ack   = w_last.flg.ack;
  assign o_c_dat_r = w_last.dat;
  assign o_b_cyc   = (r_state == ST_BUS);
  assign o_b_stb   = (r_state == ST_BUS);
  assign o_b_adr   = r_adr;
  assign o_b_sel   = r_sel;
  assign o_b_we    = r_we;
  assign o_b_dat_w = r_dat_w;

endmodule : wb_shim_port
`default_nettype wire

// File: rtl/wb_shim_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_shim_bridge                                                  |
// | Purpose  : NPORT independent Wishbone classic bridge channels between the  |
// |            core's flat master pins (c_*) and flat slave pins (b_*).        |
// | Ports    : clk, rst_n (async, active low)                                  |
// |            i_c_adr/sel/we/stb/cyc/dat_w [NPORT] : core requests            |
// |            o_c_dat_r/ack/err            [NPORT] : responses to core        |
// |            o_b_adr/sel/we/stb/cyc/dat_w [NPORT] : registered slave requests|
// |            i_b_dat_r/ack                [NPORT] : slave responses          |
// | Macro    : WB_SHIM_TIMEOUT_EN enables the per-channel BUS timeout.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wb_shim_bridge
  import wb_shim_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NPORT      = 2,
  parameter int RSP_STAGES = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NPORT-1:0][XLEN-1:0]   i_c_adr,
  input  logic [NPORT-1:0][XLEN/8-1:0] i_c_sel,
  input  logic [NPORT-1:0]             i_c_we,
  input  logic [NPORT-1:0]             i_c_stb,
  input  logic [NPORT-1:0]             i_c_cyc,
  input  logic [NPORT-1:0][XLEN-1:0]   i_c_dat_w,
  output logic [NPORT-1:0][XLEN-1:0]   o_c_dat_r,
  output logic [NPORT-1:0]             o_c_ack,
  output logic [NPORT-1:0]             o_c_err,
  output logic [NPORT-1:0][XLEN-1:0]   o_b_adr,
  output logic [NPORT-1:0][XLEN/8-1:0] o_b_sel,
  output logic [NPORT-1:0]             o_b_we,
  output logic [NPORT-1:0]             o_b_stb,
  output logic [NPORT-1:0]             o_b_cyc,
  output logic [NPORT-1:0][XLEN-1:0]   o_b_dat_w,
  input  logic [NPORT-1:0][XLEN-1:0]   i_b_dat_r,
  input  logic [NPORT-1:0]             i_b_ack
);

  if (RSP_STAGES < RSP_STAGES_MIN || RSP_STAGES > RSP_STAGES_MAX) begin : g_bad_rsp_stages
    $error("wb_shim_bridge: RSP_STAGES must be within 1..4");
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    wb_shim_port #(
      .XLEN       (XLEN),
      .RSP_STAGES (RSP_STAGES),
      .TIMEOUT    (TIMEOUT)
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_c_adr   (i_c_adr[p]),
      .i_c_sel   (i_c_sel[p]),
      .i_c_we    (i_c_we[p]),
      .i_c_stb   (i_c_stb[p]),
      .i_c_cyc   (i_c_cyc[p]),
      .i_c_dat_w (i_c_dat_w[p]),
      .o_c_dat_r (o_c_dat_r[p]),
      .o_c_ack   (o_c_ack[p]),
      .o_c_err   (o_c_err[p]),
      .o_b_adr   (o_b_adr[p]),
      .o_b_sel   (o_b_sel[p]),
      .o_b_we    (o_b_we[p]),
      .o_b_stb   (o_b_stb[p]),
      .o_b_cyc   (o_b_cyc[p]),
      .o_b_dat_w (o_b_dat_w[p]),
      .i_b_dat_r (i_b_dat_r[p]),
      .i_b_ack   (i_b_ack[p])
    );
  end

endmodule : wb_shim_bridge
`default_nettype wire

// File: tb/tb_wb_shim_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wb_shim_bridge                                               |
// | Purpose  : Scoreboard bench for wb_shim_bridge. Instance 0 uses            |
// |            RSP_STAGES=1, instance 1 uses RSP_STAGES=3; both TIMEOUT=8.     |
// |            Expected responses (cycle, data, kind) are queued by stimulus   |
// |            and popped by a negedge monitor whenever c_ack/c_err is seen.   |
// | Macro    : WB_SHIM_TIMEOUT_EN selects the timeout scenario.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_wb_shim_bridge;

  localparam int XLEN  = 32;
  localparam int NPORT = 2;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t exp_q [4][$];

  logic [NPORT-1:0][XLEN-1:0]   c_adr [2], c_dat_w [2], c_dat_r [2];
  logic [NPORT-1:0][XLEN-1:0]   b_adr [2], b_dat_w [2], b_dat_r [2];
  logic [NPORT-1:0][XLEN/8-1:0] c_sel [2], b_sel [2];
  logic [NPORT-1:0]             c_we [2], c_stb [2], c_cyc [2], c_ack [2], c_err [2];
  logic [NPORT-1:0]             b_we [2], b_stb [2], b_cyc [2], b_ack [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_shim_bridge #(
      .XLEN(XLEN), .NPORT(NPORT), .RSP_STAGES((g == 0) ? 1 : 3), .TIMEOUT(8)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_c_adr(c_adr[g]), .i_c_sel(c_sel[g]), .i_c_we(c_we[g]), .i_c_stb(c_stb[g]),
      .i_c_cyc(c_cyc[g]), .i_c_dat_w(c_dat_w[g]),
      .o_c_dat_r(c_dat_r[g]), .o_c_ack(c_ack[g]), .o_c_err(c_err[g]),
      .o_b_adr(b_adr[g]), .o_b_sel(b_sel[g]), .o_b_we(b_we[g]), .o_b_stb(b_stb[g]),
      .o_b_cyc(b_cyc[g]), .o_b_dat_w(b_dat_w[g]),
      .i_b_dat_r(b_dat_r[g]), .i_b_ack(b_ack[g])
    );
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  function automatic int rsp_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Monitor: every response seen on the core side must match the head of its queue.
  always @(negedge clk) begin
    logic a, e;
    exp_t x;
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 4; k++) begin
        a = c_ack[k/2][k%2];
        e = c_err[k/2][k%2];
        if (a || e) begin
          if (exp_q[k].size() == 0) begin
            check("spurious_rsp", {62'd0, a, e}, 64'd0);
          end else begin
            x = exp_q[k].pop_front();
            check("rsp_cycle", 64'(cyc), 64'(x.cyc));
            check("rsp_kind", {62'd0, a, e}, {62'd0, ~x.err, x.err});
            check("rsp_data", 64'(c_dat_r[k/2][k%2]), 64'(x.dat));
          end
        end
      end
    end
  end

  // One full transaction on instance k, channel ch. Called #1 after a posedge
  // with the channel idle. Slave acks in BUS cycle wt (0 = zero wait).
  // hold=1 leaves c_cyc/c_stb high after c_ack for a back-to-back request.
  task automatic txn(input int k, input int ch, input logic we, input logic [31:0] adr,
                     input logic [3:0] sel, input logic [31:0] wdat, input logic [31:0] rdat,
                     input int wt, input bit hold);
    int   t0;
    exp_t x;
    c_cyc[k][ch] = 1'b1; c_stb[k][ch] = 1'b1; c_we[k][ch] = we;
    c_adr[k][ch] = adr;  c_sel[k][ch] = sel;  c_dat_w[k][ch] = wdat;
    t0 = cyc;
    x.cyc = t0 + 1 + wt + rsp_of(k); x.dat = rdat; x.err = 1'b0;
    exp_q[k*2+ch].push_back(x);
    @(posedge clk); #1;
    for (int i = 0; i <= wt; i++) begin
      check("bus_cyc_stb", {62'd0, b_cyc[k][ch], b_stb[k][ch]}, 64'd3);
      check("bus_adr", 64'(b_adr[k][ch]), 64'(adr));
      check("bus_sel_we", {59'd0, b_sel[k][ch], b_we[k][ch]}, {59'd0, sel, we});
      check("bus_dat_w", 64'(b_dat_w[k][ch]), 64'(wdat));
      check("other_ch_idle", 64'(b_cyc[k][1-ch]), 64'd0);
      if (i == wt) begin
        b_ack[k][ch] = 1'b1; b_dat_r[k][ch] = rdat;
      end
      @(posedge clk); #1;
    end
    b_ack[k][ch] = 1'b0; b_dat_r[k][ch] = 32'hBAD0_BAD0;
    check("bus_drop", 64'(b_cyc[k][ch]), 64'd0);
    repeat (rsp_of(k)) @(posedge clk);
    #1;
    if (!hold) begin
      c_cyc[k][ch] = 1'b0; c_stb[k][ch] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t x;
    int   t0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      c_adr[k] = '0; c_dat_w[k] = '0; c_sel[k] = '0; c_we[k] = '0;
      c_stb[k] = '0; c_cyc[k] = '0; b_ack[k] = '0; b_dat_r[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_c_ack_err", {60'd0, c_ack[k], c_err[k]}, 64'd0);
      check("rst_c_dat_r", 64'(c_dat_r[k]), 64'd0);
      check("rst_b_cyc_stb", {60'd0, b_cyc[k], b_stb[k]}, 64'd0);
      check("rst_b_adr", 64'(b_adr[k]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read on ch0, slave acks one cycle after b_stb.
    txn(0, 0, 1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'hDEAD_BEEF, 1, 1'b0);
    check("t1_dat_hold", 64'(c_dat_r[0][0]), 64'hDEAD_BEEF);

    // Write on ch1 with a 5-cycle slave wait; ch0 must stay quiet.
    txn(0, 1, 1'b1, 32'h0000_0100, 4'b0011, 32'h1234_5678, 32'h0000_0000, 5, 1'b0);
    check("t2_ch0_dat", 64'(c_dat_r[0][0]), 64'hDEAD_BEEF);

    // Back-to-back reads with c_stb held, three response stages.
    txn(1, 0, 1'b0, 32'h0000_0200, 4'hF, 32'h0, 32'h1111_2222, 2, 1'b1);
    txn(1, 0, 1'b0, 32'h0000_0204, 4'hF, 32'h0, 32'h3333_4444, 0, 1'b1);
    txn(1, 0, 1'b0, 32'h0000_0208, 4'hF, 32'h0, 32'h5555_6666, 1, 1'b0);

    // Core abort in BUS coinciding with slave ack: abort wins.
    c_cyc[0][0] = 1'b1; c_stb[0][0] = 1'b1; c_we[0][0] = 1'b0; c_adr[0][0] = 32'h300;
    @(posedge clk); #1;
    check("abort_bus_up", 64'(b_cyc[0][0]), 64'd1);
    c_cyc[0][0] = 1'b0; c_stb[0][0] = 1'b0;
    b_ack[0][0] = 1'b1; b_dat_r[0][0] = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    b_ack[0][0] = 1'b0;
    check("abort_bus_drop", 64'(b_cyc[0][0]), 64'd0);
    // Stray slave ack while idle.
    repeat (2) @(posedge clk);
    #1;
    b_ack[0][0] = 1'b1;
    @(posedge clk); #1;
    b_ack[0][0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_dat_hold", 64'(c_dat_r[0][0]), 64'hDEAD_BEEF);
    check("abort_idle_bus", 64'(b_cyc[0][0]), 64'd0);
    txn(0, 0, 1'b0, 32'h0000_0304, 4'hF, 32'h0, 32'hC0DE_0001, 0, 1'b0);

`ifdef WB_SHIM_TIMEOUT_EN
    // Slave never acks: bus held for 8 cycles, then a single c_err with zero data.
    c_cyc[0][1] = 1'b1; c_stb[0][1] = 1'b1; c_we[0][1] = 1'b0; c_adr[0][1] = 32'h400;
    t0 = cyc;
    x.cyc = t0 + 9; x.dat = 32'h0; x.err = 1'b1;
    exp_q[1].push_back(x);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      check("to_bus_up", 64'(b_cyc[0][1]), 64'd1);
      @(posedge clk); #1;
    end
    check("to_bus_drop", 64'(b_cyc[0][1]), 64'd0);
    @(posedge clk); #1;
    c_cyc[0][1] = 1'b0; c_stb[0][1] = 1'b0;
    check("to_dat_zero", 64'(c_dat_r[0][1]), 64'd0);
    // Ack in the 8th BUS cycle beats expiry.
    txn(0, 1, 1'b0, 32'h0000_0404, 4'hF, 32'h0, 32'h7777_8888, 7, 1'b0);
`else
    // No timeout: a long slave wait still completes normally.
    t0 = cyc;
    x.cyc = t0;
    txn(0, 1, 1'b0, 32'h0000_0400, 4'hF, 32'h0, 32'h7777_8888, 20, 1'b0);
`endif

    // Async reset in the middle of DRAIN aborts the response.
    c_cyc[1][1] = 1'b1; c_stb[1][1] = 1'b1; c_we[1][1] = 1'b0; c_adr[1][1] = 32'h500;
    @(posedge clk); #1;
    b_ack[1][1] = 1'b1; b_dat_r[1][1] = 32'h9999_0000;
    @(posedge clk); #1;
    b_ack[1][1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async_b_cyc", 64'(b_cyc[1][1]), 64'd0);
    check("rst_async_b_adr", 64'(b_adr[1][1]), 64'd0);
    check("rst_async_dat", 64'(c_dat_r[1]), 64'd0);
    c_cyc[1][1] = 1'b0; c_stb[1][1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_dat", 64'(c_dat_r[1][1]), 64'd0);

    for (int k = 0; k < 4; k++) check("rsp_q_drained", 64'(exp_q[k].size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_wb_shim_bridge
`default_nettype wire
